fetch_sequencer: RTL and testbench

- Owns the program counter and sequences instruction-memory requests for the IF stage of the pipelined RISC-V core.
- Buffers returned instructions in a small in-order queue and presents them to decode, where the immediate generator consumes them, over a valid/ready handshake.
- Accepts redirects (branch/JAL/JALR targets resolved in EX), flushes queued instructions and discards in-flight wrong-path responses.

---
 rtl/riscv_fetch_pkg.sv | 12 +
 rtl/fetch_queue.sv | 71 +++++++
 rtl/fetch_sequencer_chk.sv | 27 ++
 rtl/fetch_sequencer.sv | 106 ++++++++++
 tb/tb_fetch_sequencer.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_fetch_pkg.sv
// Shared constants for the IF-stage fetch sequencer: reset PC, NOP encoding
// and the sequencer FSM state encoding.
package riscv_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/fetch_queue.sv
// Small in-order FIFO built as a shift register, so the head entry is always
// a flop and can drive outputs directly.
module fetch_queue #(
  parameter int               WIDTH     = 64,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              CW        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             clear,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head
);

  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    base;
  logic             do_pop;

  // Next-state: shift on pop, then write the new entry just past the survivors.
  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    do_pop  = pop && (count_q != '0);
    base    = do_pop ? (count_q - ONE) : count_q;
    if (clear) begin
      count_d = '0;
    end else begin
      if (do_pop) begin
        for (int i = 0; i < DEPTH - 1; i++) mem_d[i] = mem_q[i + 1];
      end else begin
        mem_d = mem_q;
      end
      if (push && (int'(base) < DEPTH)) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (i == int'(base)) mem_d[i] = push_data;
        end
        count_d = base + ONE;
      end else begin
        count_d = base;
      end
    end
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= RESET_VAL;
    end else begin
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

  assign full  = (count_q == FULL);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[0];

endmodule

// File: rtl/fetch_sequencer_chk.sv
// Protocol checks for the fetch sequencer's internal queues.
module fetch_sequencer_chk (
  input logic clk,
  input logic rst_n,
  input logic iq_push,
  input logic iq_pop,
  input logic iq_clear,
  input logic iq_full,
  input logic pq_push,
  input logic pq_pop,
  input logic pq_full,
  input logic pq_empty
);

  a_iq_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(iq_push && iq_full && !iq_pop && !iq_clear))
    else $error("fetch_sequencer: instruction queue push while full");

  a_pq_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(pq_push && pq_full && !pq_pop))
    else $error("fetch_sequencer: PC FIFO push while full");

  a_rsp_has_request: assert property (@(posedge clk) disable iff (!rst_n)
    !(pq_pop && pq_empty))
    else $error("fetch_sequencer: response with nothing outstanding");

endmodule

// File: rtl/fetch_sequencer.sv
// IF-stage sequencer: owns the PC, issues credit-limited fetches, queues
// returned instructions for decode and discards wrong-path responses after a redirect.
module fetch_sequencer
  import riscv_fetch_pkg::*;
#(
  parameter int               XLEN     = 32,
  parameter int               QDEPTH   = 2,
  parameter logic [XLEN-1:0]  RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc
);

  localparam int CW = $clog2(QDEPTH + 1);
  localparam int SW = CW + 2;
  localparam logic [CW-1:0] ONE = CW'(1);

  logic [XLEN-1:0]   pc_q, pc_d;
  logic [CW-1:0]     drop_q, drop_d;
  logic [1:0]        state_q, state_d;

  logic [CW-1:0]     iq_count, pq_count, inflight;
  logic              iq_full, iq_empty, pq_full, pq_empty;
  logic              iq_push, iq_pop, req_acc;
  logic [2*XLEN-1:0] iq_head;
  logic [XLEN-1:0]   pq_head;
  logic [SW-1:0]     credit_used;

  // The PC FIFO occupancy is the outstanding-request count.
  assign credit_used    = SW'(pq_count) + SW'(iq_count) + SW'(drop_q);
  assign imem_req_valid = (state_q != ST_BOOT) && !redirect_valid && (credit_used < SW'(QDEPTH));
  assign imem_req_addr  = pc_q;
  assign req_acc        = imem_req_valid && imem_req_ready;
  assign inflight       = pq_count + CW'(req_acc) - CW'(imem_rsp_valid);

  assign iq_push = imem_rsp_valid && (drop_q == '0) && !redirect_valid;
  assign iq_pop  = if_valid && if_ready && !redirect_valid;

  // PC, wrong-path drop counter and FSM next state.
  always_comb begin
    pc_d    = pc_q;
    drop_d  = drop_q;
    state_d = state_q;
    if (redirect_valid) begin
      pc_d   = redirect_pc & ~XLEN'(3);
      drop_d = inflight;
    end else begin
      if (req_acc) pc_d = pc_q + XLEN'(4);
      else         pc_d = pc_q;
      if (imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - ONE;
      else                                  drop_d = drop_q;
    end
    case (state_q)
      ST_BOOT:          state_d = ST_RUN;
      ST_RUN, ST_DRAIN: state_d = (drop_d != '0) ? ST_DRAIN : ST_RUN;
      default:          state_d = ST_BOOT;
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      drop_q  <= '0;
      state_q <= ST_BOOT;
    end else begin
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      state_q <= state_d;
    end
  end

  fetch_queue #(.WIDTH(XLEN), .DEPTH(QDEPTH), .RESET_VAL(RESET_PC)) u_pc_fifo (
    .clk(clk), .rst_n(rst_n),
    .push(req_acc), .push_data(pc_q), .pop(imem_rsp_valid), .clear(1'b0),
    .full(pq_full), .empty(pq_empty), .count(pq_count), .head(pq_head)
  );

  fetch_queue #(.WIDTH(2*XLEN), .DEPTH(QDEPTH), .RESET_VAL({RESET_PC, XLEN'(INSTR_NOP)})) u_instr_q (
    .clk(clk), .rst_n(rst_n),
    .push(iq_push), .push_data({pq_head, imem_rsp_data}), .pop(iq_pop), .clear(redirect_valid),
    .full(iq_full), .empty(iq_empty), .count(iq_count), .head(iq_head)
  );

  fetch_sequencer_chk u_chk (
    .clk(clk), .rst_n(rst_n),
    .iq_push(iq_push), .iq_pop(iq_pop), .iq_clear(redirect_valid), .iq_full(iq_full),
    .pq_push(req_acc), .pq_pop(imem_rsp_valid), .pq_full(pq_full), .pq_empty(pq_empty)
  );

  assign if_valid = !iq_empty;
  assign if_instr = iq_head[XLEN-1:0];
  assign if_pc    = iq_head[2*XLEN-1:XLEN];

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with an in-order, fixed-latency memory model.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        if_valid;
  logic        if_ready = 1'b1;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  fetch_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int lat = 1;
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  logic [31:0] issued[$];
  logic [31:0] popped[$];
  logic        s_acc, s_pop, s_rsp;
  logic [31:0] s_addr, s_pc, s_ins;

  typedef struct {
    logic        ifr;
    logic        rv;
    logic [31:0] addr;
    logic        iv;
    logic [31:0] pc;
  } vec_t;
  vec_t vt[8];

  function automatic logic [31:0] mk_instr(input logic [31:0] a);
    return a ^ 32'hA5A5_0013;
  endfunction

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Drive this cycle's memory response, let logic settle, sample handshakes.
  task automatic settle();
    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mk_instr(mq_addr[0]);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
    #1;
    s_acc  = imem_req_valid && imem_req_ready;
    s_addr = imem_req_addr;
    s_pop  = if_valid && if_ready && !redirect_valid;
    s_pc   = if_pc;
    s_ins  = if_instr;
    s_rsp  = imem_rsp_valid;
  endtask

  task automatic tick();
    @(posedge clk);
    if (s_rsp) begin
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    if (s_acc) begin
      mq_addr.push_back(s_addr);
      mq_due.push_back(cyc + lat);
      issued.push_back(s_addr);
    end
    if (s_pop) begin
      popped.push_back(s_pc);
      check("pop_instr", s_ins, mk_instr(s_pc));
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic step();
    settle();
    tick();
  endtask

  task automatic do_reset(input int l);
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    if_ready       = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    #1;
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    check("rst_req_addr", imem_req_addr, 32'h0);
    check("rst_if_valid", {31'b0, if_valid}, 32'h0);
    check("rst_if_instr", if_instr, 32'h0000_0013);
    check("rst_if_pc", if_pc, 32'h0);
    mq_addr.delete(); mq_due.delete(); issued.delete(); popped.delete();
    lat = l;
    cyc = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic count_below(input string name, input logic [31:0] lim);
    int bad;
    bad = 0;
    foreach (popped[i]) if (popped[i] < lim) bad++;
    check(name, 32'(bad), 32'h0);
  endtask

  initial begin
    int pidx, iidx;
    vt[0] = '{1'b1, 1'b0, 32'h00, 1'b0, 32'h00};
    vt[1] = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
    vt[2] = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
    vt[3] = '{1'b1, 1'b0, 32'h08, 1'b1, 32'h00};
    vt[4] = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h04};
    vt[5] = '{1'b1, 1'b1, 32'h0C, 1'b0, 32'h00};
    vt[6] = '{1'b1, 1'b0, 32'h10, 1'b1, 32'h08};
    vt[7] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h0C};

    @(negedge clk);

    // Streaming from reset with a single-cycle memory.
    do_reset(1);
    for (int i = 0; i < 8; i++) begin
      if_ready = vt[i].ifr;
      settle();
      check($sformatf("t1_req_valid[%0d]", i), {31'b0, imem_req_valid}, {31'b0, vt[i].rv});
      check($sformatf("t1_req_addr[%0d]", i), imem_req_addr, vt[i].addr);
      check($sformatf("t1_if_valid[%0d]", i), {31'b0, if_valid}, {31'b0, vt[i].iv});
      if (vt[i].iv) check($sformatf("t1_if_pc[%0d]", i), if_pc, vt[i].pc);
      tick();
    end

    // Decode stalled: credit caps fetches at QDEPTH.
    do_reset(1);
    if_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      settle();
      if (i >= 3) begin
        check("stall_if_valid", {31'b0, if_valid}, 32'h1);
        check("stall_if_pc", if_pc, 32'h0);
      end
      tick();
    end
    check("stall_issued", 32'(issued.size()), 32'd2);
    if_ready = 1'b1;
    settle();
    check("resume_no_credit", {31'b0, imem_req_valid}, 32'h0);
    tick();
    for (int i = 0; i < 10 && issued.size() < 3; i++) step();
    check("resume_issued", 32'(issued.size()), 32'd3);
    if (issued.size() >= 3) check("resume_addr", issued[2], 32'h8);

    // Redirect with two requests outstanding on a 3-cycle memory.
    do_reset(3);
    repeat (3) step();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    settle();
    check("r3_redir_req_valid", {31'b0, imem_req_valid}, 32'h0);
    tick();
    redirect_valid = 1'b0;
    settle(); check("r3_drain_c4", {31'b0, imem_req_valid}, 32'h0); tick();
    settle(); check("r3_drain_c5", {31'b0, imem_req_valid}, 32'h0); tick();
    settle();
    check("r3_first_valid", {31'b0, imem_req_valid}, 32'h1);
    check("r3_first_addr", imem_req_addr, 32'h100);
    tick();
    repeat (20) step();
    check("r3_popped_cnt_ge2", {31'b0, popped.size() >= 2}, 32'h1);
    if (popped.size() >= 2) begin
      check("r3_pc0", popped[0], 32'h100);
      check("r3_pc1", popped[1], 32'h104);
    end
    count_below("r3_old_path", 32'h100);

    // Redirect in the same cycle as an old-path response.
    do_reset(1);
    repeat (2) step();
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    settle();
    check("r4_rsp_present", {31'b0, imem_rsp_valid}, 32'h1);
    check("r4_req_blocked", {31'b0, imem_req_valid}, 32'h0);
    tick();
    redirect_valid = 1'b0;
    repeat (12) step();
    check("r4_issued_ge2", {31'b0, issued.size() >= 2}, 32'h1);
    if (issued.size() >= 2) check("r4_issue1", issued[1], 32'h200);
    check("r4_popped_ge2", {31'b0, popped.size() >= 2}, 32'h1);
    if (popped.size() >= 2) begin
      check("r4_pc0", popped[0], 32'h200);
      check("r4_pc1", popped[1], 32'h204);
    end
    count_below("r4_old_path", 32'h200);

    // Unaligned redirect target, then PC wrap at the top of the address space.
    do_reset(1);
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    step();
    redirect_valid = 1'b0;
    settle();
    check("r5_align_valid", {31'b0, imem_req_valid}, 32'h1);
    check("r5_align_addr", imem_req_addr, 32'h100);
    tick();
    repeat (5) step();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    settle();
    iidx = issued.size();
    pidx = popped.size();
    tick();
    redirect_valid = 1'b0;
    repeat (15) step();
    check("r5_wrap_issued", {31'b0, issued.size() >= iidx + 2}, 32'h1);
    if (issued.size() >= iidx + 2) begin
      check("r5_wrap_a0", issued[iidx], 32'hFFFF_FFFC);
      check("r5_wrap_a1", issued[iidx + 1], 32'h0);
    end
    check("r5_wrap_popped", {31'b0, popped.size() >= pidx + 2}, 32'h1);
    if (popped.size() >= pidx + 2) begin
      check("r5_wrap_p0", popped[pidx], 32'hFFFF_FFFC);
      check("r5_wrap_p1", popped[pidx + 1], 32'h0);
    end

    // Redirect during BOOT: BOOT still lasts exactly one cycle.
    do_reset(1);
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    settle();
    check("boot_redir_blocked", {31'b0, imem_req_valid}, 32'h0);
    tick();
    redirect_valid = 1'b0;
    settle();
    check("boot_redir_valid", {31'b0, imem_req_valid}, 32'h1);
    check("boot_redir_addr", imem_req_addr, 32'h40);
    tick();

    // Reset asserted mid-DRAIN with requests still in flight.
    do_reset(3);
    repeat (3) step();
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    step();
    redirect_valid = 1'b0;
    step();
    do_reset(1);
    step();
    settle();
    check("post_rst_valid", {31'b0, imem_req_valid}, 32'h1);
    check("post_rst_addr", imem_req_addr, 32'h0);
    tick();
    repeat (6) step();
    check("post_rst_popped", {31'b0, popped.size() >= 1}, 32'h1);
    if (popped.size() >= 1) check("post_rst_pc0", popped[0], 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
